// File: rtl/ck_burst_pkg.sv
// Shared types and helpers for the clock-burst scheduler: FSM state
// encoding, the minimum legal period and the period/high-time clamps.
package ck_burst_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DELAY = 2'd1,
        ST_HIGH  = 2'd2,
        ST_LOW   = 2'd3
    } st_e;

    // Shortest period that still has one high and one low cycle.
    localparam logic [31:0] MIN_DIV = 32'd2;

    // Period below the minimum is raised to the minimum.
    function automatic logic [31:0] clamp_div(input logic [31:0] d);
        return (d < MIN_DIV) ? MIN_DIV : d;
    endfunction

    // High time is kept inside [1, div-1] so every pulse has a low phase.
    function automatic logic [31:0] clamp_hi(input logic [31:0] h, input logic [31:0] d);
        if (h == 32'd0) return 32'd1;
        if (h >= d) return d - 32'd1;
        return h;
    endfunction

endpackage

// File: rtl/ck_burst_tmr.sv
// Loadable down-counter with a zero flag. The controller loads (length-1)
// on entry to each phase; zero marks the last cycle of that phase.
module ck_burst_tmr
    import ck_burst_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         ck,
    input  logic         ld,
    input  logic [W-1:0] ldval,
    output logic         zero
);

    logic [W-1:0] cnt;

    // Load on phase entry, otherwise count down and park at zero.
    always_ff @(posedge ck) begin
        if (ld) begin
            cnt <= ldval;
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/ck_burst_ctrl.sv
// Clock-burst scheduler: after a start request waits dly cycles, then emits
// nburst pulses of period div and high time hi on ckout, then pulses done.
// Optional feature macro: CK_BURST_CTRL_CONT_EN -- when defined, nburst==0
// means free-run until stop; when undefined, nburst==0 is an empty burst.
module ck_burst_ctrl
    import ck_burst_pkg::*;
#(
    parameter int W_DIV = 8,
    parameter int W_DLY = 16,
    parameter int W_CNT = 16
) (
    input  logic             ck,
    input  logic             rstn,
    input  logic             start,
    input  logic             stop,
    input  logic [W_DIV-1:0] div,
    input  logic [W_DIV-1:0] hi,
    input  logic [W_DLY-1:0] dly,
    input  logic [W_CNT-1:0] nburst,
    output logic             busy,
    output logic             done,
    output logic             ckout,
    output logic             ckoutb,
    output logic [W_CNT-1:0] pcnt
);

    localparam int W_TMR = (W_DIV > W_DLY) ? W_DIV : W_DLY;
    localparam logic [W_TMR-1:0] ONE_T = W_TMR'(1);

    st_e              state, state_nxt;
    logic [W_DIV-1:0] div_r, hi_r, div_c, hi_c;
    logic [W_CNT-1:0] nburst_r, pcnt_nxt;
    logic             stopf, stopf_nxt, done_nxt;
    logic             accept, empty_burst;
    logic             tmr_ld, tmr_zero;
    logic [W_TMR-1:0] tmr_val;

    function automatic logic [W_CNT-1:0] sat_inc(input logic [W_CNT-1:0] v);
        return (v == '1) ? v : v + W_CNT'(1);
    endfunction

    assign div_c = W_DIV'(clamp_div(32'(div)));
    assign hi_c  = W_DIV'(clamp_hi(32'(hi), 32'(div_c)));

`ifdef CK_BURST_CTRL_CONT_EN
    assign empty_burst = 1'b0;
`else
    assign empty_burst = (nburst == '0);
`endif

    ck_burst_tmr #(.W(W_TMR)) u_tmr (
        .ck    (ck),
        .ld    (tmr_ld),
        .ldval (tmr_val),
        .zero  (tmr_zero)
    );

    // Next-state, counter and timer-load decode for the burst sequencer.
    always_comb begin
        state_nxt = state;
        pcnt_nxt  = pcnt;
        stopf_nxt = stopf;
        done_nxt  = 1'b0;
        accept    = 1'b0;
        tmr_ld    = 1'b0;
        tmr_val   = '0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    pcnt_nxt  = '0;
                    stopf_nxt = 1'b0;
                    if (empty_burst) begin
                        done_nxt = 1'b1;
                    end else if (dly != '0) begin
                        state_nxt = ST_DELAY;
                        tmr_ld    = 1'b1;
                        tmr_val   = W_TMR'(dly) - ONE_T;
                    end else begin
                        state_nxt = ST_HIGH;
                        tmr_ld    = 1'b1;
                        tmr_val   = W_TMR'(hi_c) - ONE_T;
                        pcnt_nxt  = W_CNT'(1);
                    end
                end
            end
            ST_DELAY: begin
                if (stop) begin
                    state_nxt = ST_IDLE;
                    done_nxt  = 1'b1;
                    pcnt_nxt  = '0;
                end else if (tmr_zero) begin
                    state_nxt = ST_HIGH;
                    tmr_ld    = 1'b1;
                    tmr_val   = W_TMR'(hi_r) - ONE_T;
                    pcnt_nxt  = sat_inc(pcnt);
                end
            end
            ST_HIGH: begin
                if (stop) stopf_nxt = 1'b1;
                if (tmr_zero) begin
                    state_nxt = ST_LOW;
                    tmr_ld    = 1'b1;
                    tmr_val   = W_TMR'(div_r - hi_r) - ONE_T;
                end
            end
            ST_LOW: begin
                if (stop) stopf_nxt = 1'b1;
                if (tmr_zero) begin
                    // A stop seen anywhere in this pulse ends the burst after it.
                    if (stopf || stop || ((nburst_r != '0) && (pcnt == nburst_r))) begin
                        state_nxt = ST_IDLE;
                        done_nxt  = 1'b1;
                    end else begin
                        state_nxt = ST_HIGH;
                        tmr_ld    = 1'b1;
                        tmr_val   = W_TMR'(hi_r) - ONE_T;
                        pcnt_nxt  = sat_inc(pcnt);
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State register and registered outputs.
    always_ff @(posedge ck) begin
        if (!rstn) begin
            state  <= ST_IDLE;
            pcnt   <= '0;
            stopf  <= 1'b0;
            done   <= 1'b0;
            busy   <= 1'b0;
            ckout  <= 1'b0;
            ckoutb <= 1'b1;
        end else begin
            state  <= state_nxt;
            pcnt   <= pcnt_nxt;
            stopf  <= stopf_nxt;
            done   <= done_nxt;
            busy   <= (state_nxt != ST_IDLE);
            ckout  <= (state_nxt == ST_HIGH);
            ckoutb <= (state_nxt != ST_HIGH);
        end
    end

    // Burst configuration captured in the accept cycle only.
    always_ff @(posedge ck) begin
        if (accept) begin
            div_r    <= div_c;
            hi_r     <= hi_c;
            nburst_r <= nburst;
        end
    end

endmodule

// File: tb/tb_ck_burst_ctrl.sv
// Scoreboard bench for ck_burst_ctrl: the driver computes each burst's
// waveform and completion from period/high/delay arithmetic and queues the
// expected done event; a negedge monitor compares every cycle.
module tb_ck_burst_ctrl;

    logic        ck;
    logic        rstn;
    logic        start, stop;
    logic [7:0]  div, hi;
    logic [15:0] dly, nburst;
    logic        busy, done, ckout, ckoutb;
    logic [15:0] pcnt;

    ck_burst_ctrl dut (
        .ck     (ck),
        .rstn   (rstn),
        .start  (start),
        .stop   (stop),
        .div    (div),
        .hi     (hi),
        .dly    (dly),
        .nburst (nburst),
        .busy   (busy),
        .done   (done),
        .ckout  (ckout),
        .ckoutb (ckoutb),
        .pcnt   (pcnt)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    typedef struct {
        int cyc;
        int pcnt;
    } exp_t;

    localparam int BIG = 1 << 30;

    exp_t q[$];
    int   cyc = 0;
    logic rst_prev = 1'b0;
    int   checks = 0;
    int   errors = 0;

    // Reference model of the current burst.
    int b_t = 0, b_dly = 0, b_div = 2, b_hi = 1, b_end = 0;

    always @(posedge ck) begin
        cyc      <= cyc + 1;
        rst_prev <= !rstn;
    end

    function automatic bit m_busy(int c);
        return (c >= b_t + 1) && (c < b_end);
    endfunction

    function automatic bit m_ck(int c);
        int s;
        s = b_t + 1 + b_dly;
        if (c < s || c >= b_end) return 1'b0;
        return ((c - s) % b_div) < b_hi;
    endfunction

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
        end
    endfunction

    // Monitor: per-cycle waveform checks and done-event scoreboard.
    always @(negedge ck) begin
        exp_t e;
        if (rst_prev) begin
            chk("rst_ckout", 32'(ckout), 32'd0);
            chk("rst_ckoutb", 32'(ckoutb), 32'd1);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_done", 32'(done), 32'd0);
            chk("rst_pcnt", 32'(pcnt), 32'd0);
            q.delete();
        end else begin
            chk("ckout", 32'(ckout), 32'(m_ck(cyc)));
            chk("ckoutb", 32'(ckoutb), 32'(!m_ck(cyc)));
            chk("busy", 32'(busy), 32'(m_busy(cyc)));
            if (done === 1'b1) begin
                if (q.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("done_cycle", 32'(cyc), 32'(e.cyc));
                    chk("done_pcnt", 32'(pcnt), 32'(e.pcnt));
                end
            end else if (q.size() > 0 && cyc > q[0].cyc) begin
                chk("missing_done", 32'(cyc), 32'(q[0].cyc));
                e = q.pop_front();
            end
        end
    end

    // Advance one cycle; inputs default to idle with garbage config.
    task automatic tick();
        @(posedge ck);
        #1;
        start  = 1'b0;
        stop   = 1'b0;
        div    = 8'($urandom);
        hi     = 8'($urandom);
        dly    = 16'($urandom);
        nburst = 16'($urandom);
    endtask

    task automatic do_start(int d, int h, int dl, int nb);
        exp_t e;
        int   dc, hc;
        start  = 1'b1;
        div    = 8'(d);
        hi     = 8'(h);
        dly    = 16'(dl);
        nburst = 16'(nb);
        if (!m_busy(cyc)) begin
            dc = (d < 2) ? 2 : d;
            hc = (h == 0) ? 1 : ((h >= dc) ? dc - 1 : h);
            b_t = cyc; b_dly = dl; b_div = dc; b_hi = hc;
            if (nb == 0) begin
`ifdef CK_BURST_CTRL_CONT_EN
                b_end = BIG;
`else
                b_end = cyc + 1;
`endif
            end else begin
                b_end = cyc + 1 + dl + nb * dc;
            end
            e.cyc = b_end;
            e.pcnt = nb;
            q.push_back(e);
        end
    endtask

    task automatic do_stop();
        int s, k;
        stop = 1'b1;
        s = b_t + 1 + b_dly;
        if (m_busy(cyc) && q.size() > 0) begin
            if (cyc < s) begin
                b_end = cyc + 1;
                q[q.size()-1].cyc = b_end;
                q[q.size()-1].pcnt = 0;
            end else begin
                k = (cyc - s) / b_div;
                b_end = s + (k + 1) * b_div;
                q[q.size()-1].cyc = b_end;
                q[q.size()-1].pcnt = k + 1;
            end
        end
    endtask

    task automatic run_idle();
        for (int g = 0; g < 1000 && cyc < b_end; g++) tick();
    endtask

    initial begin
        rstn = 1'b0;
        start = 1'b0; stop = 1'b0;
        div = '0; hi = '0; dly = '0; nburst = '0;
        tick(); tick(); tick();
        rstn = 1'b1;
        tick();

        // Basic burst, then clamped high time with delay.
        do_start(4, 1, 0, 3);        run_idle(); tick();
        do_start(5, 7, 2, 2);        run_idle(); tick();

        // Stop in second pulse; stop during delay; start+stop in IDLE.
        do_start(4, 2, 0, 5);
        repeat (6) tick();
        do_stop();                   run_idle(); tick();
        do_start(3, 1, 5, 2);
        tick(); do_stop();           run_idle(); tick();
        do_start(3, 2, 0, 1); do_stop(); run_idle(); tick();

        // Start while busy ignored; start in done cycle accepted.
        do_start(3, 1, 0, 4);
        tick(); tick();
        do_start(7, 3, 0, 2);
        run_idle();
        do_start(2, 1, 1, 2);        run_idle(); tick();

        // Empty or free-running burst.
        do_start(4, 2, 1, 0);
`ifdef CK_BURST_CTRL_CONT_EN
        repeat (10) tick();
        do_stop();
`endif
        run_idle(); tick();

        // Reset in the middle of a high phase.
        do_start(6, 3, 1, 4);
        repeat (3) tick();
        rstn = 1'b0;
        b_end = cyc + 1;
        tick();
        rstn = 1'b1;
        tick();

        // Randomized bursts with random stops and restart attempts.
        for (int n = 0; n < 40; n++) begin
            repeat ($urandom_range(0, 2)) tick();
            do_start($urandom_range(0, 9), $urandom_range(0, 10),
                     $urandom_range(0, 4), $urandom_range(0, 4));
            for (int g = 0; g < 300 && cyc < b_end; g++) begin
                tick();
                if ($urandom_range(0, 19) == 0)
                    do_start($urandom_range(0, 9), $urandom_range(0, 10),
                             $urandom_range(0, 4), $urandom_range(0, 4));
                if ($urandom_range(0, 24) == 0 || g == 40) do_stop();
            end
        end

        repeat (5) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
